// File: rtl/dmr_fork_pkg.sv
// Shared vote-mode type and bit-counting helpers for redundant handshake forks.
// Helpers accept up to MaxLanes lanes; callers zero-extend narrower vectors.
package dmr_fork_pkg;

    typedef enum logic {
        VoteUnanimous,
        VoteMajority
    } fork_vote_e;

    localparam int unsigned MaxLanes = 32;

    function automatic int unsigned popcount(input logic [MaxLanes-1:0] bits);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MaxLanes; i++) begin
            cnt += {31'd0, bits[i]};
        end
        return cnt;
    endfunction

    function automatic logic majority(input logic [MaxLanes-1:0] bits, input int unsigned lanes);
        return popcount(bits) > (lanes / 2);
    endfunction

endpackage

// File: rtl/dmr_ready_voter.sv
// Combinational vote, mismatch and per-lane fault mask over redundant ready lines.
// Zero latency; purely combinational, so it adds no backpressure of its own.
module dmr_ready_voter
    import dmr_fork_pkg::*;
#(
    parameter int unsigned NUM_OUT   = 3,
    parameter fork_vote_e  VOTE_MODE = VoteUnanimous
) (
    input  logic [NUM_OUT-1:0] ready_i,
    output logic               vote_o,
    output logic               mismatch_o,
    output logic [NUM_OUT-1:0] fault_mask_o
);

    logic [MaxLanes-1:0] ready_ext;

    always_comb begin
        ready_ext                = '0;
        ready_ext[NUM_OUT-1:0]   = ready_i;
        if (VOTE_MODE == VoteMajority) begin
            vote_o = majority(ready_ext, NUM_OUT);
        end else begin
            vote_o = &ready_i;
        end
        mismatch_o   = (|ready_i) & ~(&ready_i);
        fault_mask_o = ready_i ^ {NUM_OUT{vote_o}};
    end

endmodule

// File: rtl/dmr_handshake_fork_buffered.sv
// Buffered fork from one source to NUM_OUT redundant destinations with ready voting.
// Push-to-valid latency 1 cycle (no fall-through); source ready depends on fill only when enabled.
module dmr_handshake_fork_buffered
    import dmr_fork_pkg::*;
#(
    parameter type         T         = logic,
    parameter int unsigned NUM_OUT   = 3,
    parameter int unsigned DEPTH     = 2,
    parameter fork_vote_e  VOTE_MODE = VoteUnanimous,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         error_before_i,
    input  logic                         error_after_i,
    output logic                         error_o,
    output logic [NUM_OUT-1:0]           fault_mask_o,
    output logic [CNT_WIDTH-1:0]         mismatch_cnt_o,
    input  logic                         clear_cnt_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  T                             data_i,
    output logic [NUM_OUT-1:0]           valid_o,
    input  logic [NUM_OUT-1:0]           ready_i,
    output T                             data_o [NUM_OUT],
    output logic [$clog2(DEPTH+1)-1:0]   fill_o
);

    localparam int unsigned FILL_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [FILL_W-1:0]    FULL     = FILL_W'(DEPTH);
    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    T                     mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic               vote;
    logic               mismatch;
    logic [NUM_OUT-1:0] lane_fault;
    logic               not_empty;
    logic               push;
    logic               pop;
    T                   head;

    dmr_ready_voter #(
        .NUM_OUT   (NUM_OUT),
        .VOTE_MODE (VOTE_MODE)
    ) u_voter (
        .ready_i      (ready_i),
        .vote_o       (vote),
        .mismatch_o   (mismatch),
        .fault_mask_o (lane_fault)
    );

    assign not_empty = (fill_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // Only unanimous mode stalls on disagreement; majority mode just reports it.
    assign push = enable_i & valid_i & (fill_q != FULL);
    assign pop  = enable_i & not_empty & vote & ~error_before_i & ~error_after_i
                & ~(mismatch & (VOTE_MODE == VoteUnanimous));

    always_comb begin
        ready_o      = enable_i ? (fill_q != FULL) : ready_i[0];
        valid_o      = enable_i ? {NUM_OUT{not_empty}} : {{(NUM_OUT-1){1'b0}}, valid_i};
        error_o      = enable_i & mismatch;
        fault_mask_o = enable_i ? lane_fault : '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            data_o[i] = enable_i ? head : data_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        if (!enable_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop) begin
                fill_d = fill_q + 1'b1;
            end else if (pop && !push) begin
                fill_d = fill_q - 1'b1;
            end
        end
        if (clear_cnt_i) begin
            cnt_d = '0;
        end else if (error_o && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while fill is non-zero.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    assign fill_o         = fill_q;
    assign mismatch_cnt_o = cnt_q;

endmodule

// File: tb/tb_dmr_handshake_fork_buffered.sv
// Bench for the buffered redundant fork: a unanimous DEPTH=2 and a majority DEPTH=3 instance
// share stimulus and are each checked against a queue-based reference model.
module tb_dmr_handshake_fork_buffered;
    import dmr_fork_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       eb;
    logic       ea;
    logic       clr;
    logic       vi;
    logic [7:0] di;
    logic [2:0] rdy;

    logic       u_err, m_err;
    logic [2:0] u_fm, m_fm;
    logic [7:0] u_cnt, m_cnt;
    logic       u_rdy, m_rdy;
    logic [2:0] u_vld, m_vld;
    logic [7:0] u_dat [3];
    logic [7:0] m_dat [3];
    logic [1:0] u_fill, m_fill;

    int tests = 0;
    int fails = 0;

    logic [7:0] uq [$];
    logic [7:0] mq [$];
    int         ucnt = 0;
    int         mcnt = 0;

    dmr_handshake_fork_buffered #(
        .T(logic [7:0]), .NUM_OUT(3), .DEPTH(2), .VOTE_MODE(VoteUnanimous), .CNT_WIDTH(8)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .error_before_i(eb), .error_after_i(ea),
        .error_o(u_err), .fault_mask_o(u_fm), .mismatch_cnt_o(u_cnt), .clear_cnt_i(clr),
        .valid_i(vi), .ready_o(u_rdy), .data_i(di), .valid_o(u_vld), .ready_i(rdy),
        .data_o(u_dat), .fill_o(u_fill)
    );

    dmr_handshake_fork_buffered #(
        .T(logic [7:0]), .NUM_OUT(3), .DEPTH(3), .VOTE_MODE(VoteMajority), .CNT_WIDTH(8)
    ) m_dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .error_before_i(eb), .error_after_i(ea),
        .error_o(m_err), .fault_mask_o(m_fm), .mismatch_cnt_o(m_cnt), .clear_cnt_i(clr),
        .valid_i(vi), .ready_o(m_rdy), .data_i(di), .valid_o(m_vld), .ready_i(rdy),
        .data_o(m_dat), .fill_o(m_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy;
        logic [2:0] vld;
        logic [7:0] dat;
        logic       err;
        logic [2:0] fm;
        logic       pop;
        logic       push;
    } exp_t;

    // Expected behaviour from the rules: queue occupancy, ready-vote arithmetic, bypass wiring.
    function automatic exp_t model(input bit maj, input int depth, input int size,
                                   input logic [7:0] head);
        exp_t e;
        int   ones;
        bit   vote;
        bit   mism;
        ones = int'(rdy[0]) + int'(rdy[1]) + int'(rdy[2]);
        vote = maj ? (ones >= 2) : (ones == 3);
        mism = (ones == 1) || (ones == 2);
        e    = '0;
        if (en) begin
            e.rdy  = (size < depth);
            e.vld  = (size != 0) ? 3'b111 : 3'b000;
            e.dat  = head;
            e.err  = mism;
            e.fm   = rdy ^ {3{vote}};
            e.pop  = (size != 0) && vote && !eb && !ea && !(mism && !maj);
            e.push = vi && (size < depth);
        end else begin
            e.rdy = rdy[0];
            e.vld = {2'b00, vi};
            e.dat = di;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_cnt(input int cnt, input bit err);
        if (clr) return 0;
        if (err) return (cnt < 255) ? cnt + 1 : 255;
        return cnt;
    endfunction

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic step();
        exp_t eu;
        exp_t em;
        #2;
        eu = model(1'b0, 2, uq.size(), (uq.size() != 0) ? uq[0] : 8'h00);
        em = model(1'b1, 3, mq.size(), (mq.size() != 0) ? mq[0] : 8'h00);
        chk("u_ready", 32'(u_rdy), 32'(eu.rdy));
        chk("u_valid", 32'(u_vld), 32'(eu.vld));
        chk("u_error", 32'(u_err), 32'(eu.err));
        chk("u_fmask", 32'(u_fm), 32'(eu.fm));
        chk("u_fill", 32'(u_fill), en ? 32'(uq.size()) : 32'(u_fill));
        chk("u_cnt", 32'(u_cnt), 32'(ucnt));
        chk("m_ready", 32'(m_rdy), 32'(em.rdy));
        chk("m_valid", 32'(m_vld), 32'(em.vld));
        chk("m_error", 32'(m_err), 32'(em.err));
        chk("m_fmask", 32'(m_fm), 32'(em.fm));
        chk("m_fill", 32'(m_fill), en ? 32'(mq.size()) : 32'(m_fill));
        chk("m_cnt", 32'(m_cnt), 32'(mcnt));
        for (int i = 0; i < 3; i++) begin
            if (eu.vld != 3'b000 || !en) chk("u_data", 32'(u_dat[i]), 32'(eu.dat));
            if (em.vld != 3'b000 || !en) chk("m_data", 32'(m_dat[i]), 32'(em.dat));
        end
        @(posedge clk);
        #1;
        if (!en) begin
            uq.delete();
            mq.delete();
        end else begin
            if (eu.pop)  void'(uq.pop_front());
            if (eu.push) uq.push_back(di);
            if (em.pop)  void'(mq.pop_front());
            if (em.push) mq.push_back(di);
        end
        ucnt = next_cnt(ucnt, eu.err);
        mcnt = next_cnt(mcnt, em.err);
    endtask

    task automatic check_reset_state();
        chk("rst_u_fill", 32'(u_fill), 32'd0);
        chk("rst_m_fill", 32'(m_fill), 32'd0);
        chk("rst_u_cnt", 32'(u_cnt), 32'd0);
        chk("rst_m_cnt", 32'(m_cnt), 32'd0);
        chk("rst_u_valid", 32'(u_vld), 32'd0);
        chk("rst_m_valid", 32'(m_vld), 32'd0);
        chk("rst_u_ready", 32'(u_rdy), 32'd1);
        chk("rst_m_ready", 32'(m_rdy), 32'd1);
        uq.delete();
        mq.delete();
        ucnt = 0;
        mcnt = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b1; eb = 1'b0; ea = 1'b0; clr = 1'b0;
        vi = 1'b0; di = 8'h00; rdy = 3'b111;
        #3;
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming with all destinations ready.
        rdy = 3'b111;
        vi = 1'b1; di = 8'hA1; step();
        di = 8'hB2; step();
        di = 8'hC3; step();
        vi = 1'b0; step();
        step();

        // Backpressure fills the FIFO, then drains in order.
        rdy = 3'b000;
        vi = 1'b1; di = 8'h11; step();
        di = 8'h22; step();
        chk("full_u_fill", 32'(u_fill), 32'd2);
        chk("full_u_ready", 32'(u_rdy), 32'd0);
        di = 8'h33; step();
        step();
        rdy = 3'b111;
        for (int i = 0; i < 6; i++) begin
            if (u_rdy) vi = 1'b0;
            step();
        end
        vi = 1'b0;

        // Split readies for three cycles hold the unanimous head and count mismatches.
        rdy = 3'b000;
        vi = 1'b1; di = 8'h5A; step();
        vi = 1'b0;
        rdy = 3'b101;
        for (int i = 0; i < 3; i++) step();
        chk("split_u_cnt", 32'(u_cnt), 32'd3);
        rdy = 3'b111; step();
        step();

        // Majority masks a single dissenting lane.
        rdy = 3'b000;
        vi = 1'b1; di = 8'h6B; step();
        vi = 1'b0;
        rdy = 3'b110; step();
        step();

        // Downstream and upstream error flags each repeat the transaction once.
        rdy = 3'b000;
        vi = 1'b1; di = 8'h7C; step();
        vi = 1'b0; rdy = 3'b111;
        ea = 1'b1; step();
        ea = 1'b0; step();
        rdy = 3'b000;
        vi = 1'b1; di = 8'h8D; step();
        vi = 1'b0; rdy = 3'b111;
        eb = 1'b1; step();
        eb = 1'b0; step();
        step();

        // Randomised traffic including bypass, error flags and counter clears.
        for (int n = 0; n < 400; n++) begin
            en  = ($urandom_range(0, 9) != 0);
            vi  = $urandom_range(0, 1) == 1;
            di  = 8'($urandom);
            rdy = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
            eb  = ($urandom_range(0, 7) == 0);
            ea  = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 31) == 0);
            step();
        end
        en = 1'b1; eb = 1'b0; ea = 1'b0; clr = 1'b0; vi = 1'b0;

        // Counter saturation, then clear taking priority over increment.
        rdy = 3'b101;
        for (int n = 0; n < 300; n++) step();
        chk("sat_u_cnt", 32'(u_cnt), 32'd255);
        chk("sat_m_cnt", 32'(m_cnt), 32'd255);
        clr = 1'b1; step();
        clr = 1'b0;
        chk("clr_u_cnt", 32'(u_cnt), 32'd0);
        chk("clr_m_cnt", 32'(m_cnt), 32'd0);

        // Bypass mode.
        en = 1'b0;
        vi = 1'b1; di = 8'h9E; rdy = 3'b001; step();
        vi = 1'b0; di = 8'h3F; rdy = 3'b110; step();
        chk("byp_u_fill", 32'(u_fill), 32'd0);
        chk("byp_m_fill", 32'(m_fill), 32'd0);

        // Asynchronous reset while entries are buffered.
        en = 1'b1; rdy = 3'b000;
        vi = 1'b1; di = 8'h44; step();
        di = 8'h55; step();
        vi = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy = 3'b111;
        vi = 1'b1; di = 8'h66; step();
        vi = 1'b0; step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
